fft_256_engine: RTL and testbench

- 256-point radix-2 decimation-in-time complex FFT of a real, signed, time-domain frame.
- Sits between the audio sample buffer and the spectrum/magnitude display path of the visualizer.
- Single-shot: one frame per `start`. The iterative datapath computes one full butterfly stage per clock.
- Outputs are scaled by 1/N so they fit WIDTH+1 bits.

---
 rtl/fft_256_engine.sv | 212 +++++++++++++++++++++
 tb/tb_fft_256_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_256_engine.sv
// 256-point radix-2 decimation-in-time FFT: one full butterfly stage per clock, outputs scaled by 1/N.
// Optional macro FFT_MAG_EN adds freq_mag, an alpha-max/beta-min magnitude estimate per bin.

module fft_256_engine #(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned N        = 256,
    parameter int unsigned TW_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    done,
    input  logic signed [WIDTH-1:0] time_samples [N],
    output logic signed [WIDTH:0]   freq_real    [N],
    output logic signed [WIDTH:0]   freq_imag    [N]
`ifdef FFT_MAG_EN
    ,
    output logic        [WIDTH+1:0] freq_mag     [N]
`endif
);

    localparam int unsigned STAGES  = 8;
    localparam int unsigned SW      = 3;
    localparam int unsigned HALF    = N / 2;
    localparam int unsigned OW      = WIDTH + 1;
    localparam int unsigned AW      = WIDTH + 4;
    localparam int unsigned PW      = OW + TW_WIDTH + 1;
    localparam int unsigned TW_FRAC = TW_WIDTH - 2;

    // Quarter-wave table: round(1024 * sin(2*pi*k/256)), k = 0..64
    localparam int SIN_Q [65] = '{
           0,   25,   50,   75,  100,  125,  150,  175,  200,  224,
         249,  273,  297,  321,  345,  369,  392,  415,  438,  460,
         483,  505,  526,  548,  569,  590,  610,  630,  650,  669,
         688,  706,  724,  742,  759,  775,  792,  807,  822,  837,
         851,  865,  878,  891,  903,  915,  926,  936,  946,  955,
         964,  972,  980,  987,  993,  999, 1004, 1009, 1013, 1016,
        1019, 1021, 1023, 1024, 1024
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    function automatic int tw_cos(input int unsigned t);
        return (t <= 64) ? SIN_Q[7'(64 - t)] : -SIN_Q[7'(t - 64)];
    endfunction

    function automatic int tw_sin(input int unsigned t);
        return (t <= 64) ? SIN_Q[7'(t)] : SIN_Q[7'(128 - t)];
    endfunction

    function automatic int unsigned bitrev8(input int unsigned x);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            r = r | (((x >> i) & 32'd1) << (7 - i));
        end
        return r;
    endfunction

    state_e               state_q, state_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic                 done_q, done_d;
    logic                 load_c, step_c, publish_c;

    logic signed [OW-1:0] work_re_q [N];
    logic signed [OW-1:0] work_re_d [N];
    logic signed [OW-1:0] work_im_q [N];
    logic signed [OW-1:0] work_im_d [N];
    logic signed [OW-1:0] out_re_q  [N];
    logic signed [OW-1:0] out_re_d  [N];
    logic signed [OW-1:0] out_im_q  [N];
    logic signed [OW-1:0] out_im_d  [N];
    logic signed [OW-1:0] load_re   [N];
    logic signed [OW-1:0] st_re     [STAGES][N];
    logic signed [OW-1:0] st_im     [STAGES][N];

    // Bit-reversed, sign-extended view of the input frame
    for (genvar i = 0; i < N; i++) begin : g_load
        localparam int unsigned SRC = bitrev8(i);
        assign load_re[i] = OW'(time_samples[SRC]);
    end

    // Every stage's butterflies read the working registers; the stage counter picks one result set
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        for (genvar b = 0; b < HALF; b++) begin : g_bfly
            localparam int unsigned H  = 32'd1 << s;
            localparam int unsigned JI = b % H;
            localparam int unsigned J  = (b / H) * 2 * H + JI;
            localparam int unsigned K  = J + H;
            localparam int unsigned T  = JI * (HALF >> s);
            localparam logic signed [TW_WIDTH-1:0] WR = TW_WIDTH'(tw_cos(T));
            localparam logic signed [TW_WIDTH-1:0] WS = TW_WIDTH'(tw_sin(T));

            logic signed [PW-1:0] pr_full, pi_full;
            logic signed [AW-1:0] p_re, p_im, a_re, a_im;

            // W = WR - j*WS, so W*b = (WR*br + WS*bi) + j(WR*bi - WS*br)
            assign pr_full = PW'(WR) * PW'(work_re_q[K]) + PW'(WS) * PW'(work_im_q[K]);
            assign pi_full = PW'(WR) * PW'(work_im_q[K]) - PW'(WS) * PW'(work_re_q[K]);
            assign p_re    = AW'(pr_full >>> TW_FRAC);
            assign p_im    = AW'(pi_full >>> TW_FRAC);
            assign a_re    = AW'(work_re_q[J]);
            assign a_im    = AW'(work_im_q[J]);

            assign st_re[s][J] = OW'((a_re + p_re) >>> 1);
            assign st_im[s][J] = OW'((a_im + p_im) >>> 1);
            assign st_re[s][K] = OW'((a_re - p_re) >>> 1);
            assign st_im[s][K] = OW'((a_im - p_im) >>> 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                end
            end
            RUN: begin
                stage_d = stage_q + SW'(1);
                if (stage_q == SW'(STAGES - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_c    = 1'b0;
        step_c    = 1'b0;
        publish_c = 1'b0;
        case (state_q)
            IDLE:    load_c    = start;
            RUN:     step_c    = 1'b1;
            FINISH:  publish_c = 1'b1;
            default: ;
        endcase
        done_d = publish_c;
    end

    always_comb begin
        work_re_d = work_re_q;
        work_im_d = work_im_q;
        out_re_d  = out_re_q;
        out_im_d  = out_im_q;
        if (load_c) begin
            work_re_d = load_re;
            work_im_d = '{default: '0};
        end else if (step_c) begin
            work_re_d = st_re[stage_q];
            work_im_d = st_im[stage_q];
        end
        if (publish_c) begin
            out_re_d = work_re_q;
            out_im_d = work_im_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_re_q <= '{default: '0};
            work_im_q <= '{default: '0};
            out_re_q  <= '{default: '0};
            out_im_q  <= '{default: '0};
        end else begin
            work_re_q <= work_re_d;
            work_im_q <= work_im_d;
            out_re_q  <= out_re_d;
            out_im_q  <= out_im_d;
        end
    end

    assign done      = done_q;
    assign freq_real = out_re_q;
    assign freq_imag = out_im_q;

`ifdef FFT_MAG_EN
    localparam int unsigned MW = WIDTH + 2;

    // max + 3/8 min; |-2^WIDTH| still fits OW bits when read as unsigned
    for (genvar k = 0; k < N; k++) begin : g_mag
        logic [OW-1:0] abs_re, abs_im, mx, mn;
        assign abs_re      = out_re_q[k][OW-1] ? OW'(-out_re_q[k]) : OW'(out_re_q[k]);
        assign abs_im      = out_im_q[k][OW-1] ? OW'(-out_im_q[k]) : OW'(out_im_q[k]);
        assign mx          = (abs_re >= abs_im) ? abs_re : abs_im;
        assign mn          = (abs_re >= abs_im) ? abs_im : abs_re;
        assign freq_mag[k] = MW'(mx) + MW'(mn >> 2) + MW'(mn >> 3);
    end
`endif

endmodule

// File: tb/tb_fft_256_engine.sv
// Scoreboard bench for fft_256_engine: expected spectra are queued at start and checked at done.
// Define FFT_MAG_EN for both files to also exercise freq_mag.

module tb_fft_256_engine;

    localparam int unsigned WIDTH  = 12;
    localparam int unsigned NP     = 256;
    localparam real         TWO_PI = 6.283185307179586;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    done;
    logic signed [WIDTH-1:0] ts [NP];
    logic signed [WIDTH:0]   fr [NP];
    logic signed [WIDTH:0]   fi [NP];
`ifdef FFT_MAG_EN
    logic        [WIDTH+1:0] fm [NP];
`endif

    int  x   [NP];
    int  mix [NP];
    real exp_re_q [$];
    real exp_im_q [$];
    real tol_q    [$];
    int  n_checks = 0;
    int  n_fail   = 0;

    fft_256_engine #(
        .WIDTH        (WIDTH),
        .N            (NP),
        .TW_WIDTH     (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .done         (done),
        .time_samples (ts),
        .freq_real    (fr),
        .freq_imag    (fi)
`ifdef FFT_MAG_EN
        ,
        .freq_mag     (fm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input real got, input real exp, input real tol);
        n_checks++;
        if ((got > exp + tol) || (got < exp - tol)) begin
            n_fail++;
            $display("FAIL %s: got %.2f expected %.2f (tol %.1f)", tag, got, exp, tol);
        end
    endtask

    task automatic push_exp(input real re, input real im, input real tol);
        exp_re_q.push_back(re);
        exp_im_q.push_back(im);
        tol_q.push_back(tol);
    endtask

    // Double-precision DFT of x[], scaled by 1/256
    task automatic push_dft(input real tol);
        real sr, si, ang;
        for (int k = 0; k < NP; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < NP; n++) begin
                ang = TWO_PI * real'((k * n) % NP) / real'(NP);
                sr  = sr + real'(x[n]) * $cos(ang);
                si  = si - real'(x[n]) * $sin(ang);
            end
            push_exp(sr / real'(NP), si / real'(NP), tol);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < NP; k++) begin
            check($sformatf("%s re[%0d]", name, k), real'(fr[k]), 0.0, 0.0);
            check($sformatf("%s im[%0d]", name, k), real'(fi[k]), 0.0, 0.0);
`ifdef FFT_MAG_EN
            check($sformatf("%s mag[%0d]", name, k), real'(fm[k]), 0.0, 0.0);
`endif
        end
        check({name, " done"}, real'(done), 0.0, 0.0);
    endtask

    // Drive x[] and pulse start; optionally re-pulse start with junk data at restart_at
    task automatic run_frame(input string name, input int restart_at, input int tail);
        int  got;
        real re, im, tol;
        for (int i = 0; i < NP; i++) ts[i] = WIDTH'(x[i]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int cyc = 1; cyc <= 20 && got == 0; cyc++) begin
            if (cyc == restart_at) begin
                start = 1'b1;
                for (int i = 0; i < NP; i++) ts[i] = 12'sd2047;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) got = cyc;
        end
        if (got == 0) begin
            check({name, " done timeout"}, 0.0, 1.0, 0.0);
            for (int k = 0; k < NP; k++) begin
                re  = exp_re_q.pop_front();
                im  = exp_im_q.pop_front();
                tol = tol_q.pop_front();
            end
        end else begin
            check({name, " latency"}, real'(got), 9.0, 0.0);
            for (int k = 0; k < NP; k++) begin
                re  = exp_re_q.pop_front();
                im  = exp_im_q.pop_front();
                tol = tol_q.pop_front();
                check($sformatf("%s re[%0d]", name, k), real'(fr[k]), re, tol);
                check($sformatf("%s im[%0d]", name, k), real'(fi[k]), im, tol);
            end
        end
        for (int t = 0; t < tail; t++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s no extra done +%0d", name, t + 1), real'(done), 0.0, 0.0);
        end
    endtask

    task automatic load_impulse();
        for (int i = 0; i < NP; i++) x[i] = 0;
        x[0] = 256;
        for (int k = 0; k < NP; k++) push_exp(1.0, 0.0, 0.0);
    endtask

    task automatic load_dc();
        for (int i = 0; i < NP; i++) x[i] = 100;
        push_exp(100.0, 0.0, 0.0);
        for (int k = 1; k < NP; k++) push_exp(0.0, 0.0, 1.0);
    endtask

    task automatic load_cosine();
        real v;
        for (int n = 0; n < NP; n++) begin
            v    = 1000.0 * $cos(TWO_PI * 8.0 * real'(n) / real'(NP));
            x[n] = $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
        end
        for (int k = 0; k < NP; k++) begin
            if (k == 8 || k == 248) push_exp(500.0, 0.0, 4.0);
            else                    push_exp(0.0, 0.0, 4.0);
        end
    endtask

    task automatic load_mixed();
        for (int i = 0; i < NP; i++) x[i] = mix[i];
        push_dft(8.0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mix[0] = -32;
        mix[1] = -185;
        mix[2] = -128;
        mix[3] = -178;
        mix[4] = 99;
        for (int i = 5; i < NP; i++) mix[i] = int'($urandom_range(400, 0)) - 200;

        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NP; i++) ts[i] = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        load_impulse();
        run_frame("impulse", 0, 1);

        load_dc();
        run_frame("dc", 0, 1);

        load_cosine();
        run_frame("cosine", 0, 1);
`ifdef FFT_MAG_EN
        check("cosine mag[8]", real'(fm[8]), 500.0, 8.0);
        check("cosine mag[248]", real'(fm[248]), 500.0, 8.0);
        check("cosine mag[3]", real'(fm[3]), 0.0, 6.0);
`endif

        load_mixed();
        run_frame("mixed+restart", 3, 12);

        load_impulse();
        run_frame("b2b first", 0, 0);
        load_dc();
        run_frame("b2b second", 0, 1);

        // Abort a cosine frame mid-run; outputs must clear and no done may follow
        load_cosine();
        exp_re_q.delete();
        exp_im_q.delete();
        tol_q.delete();
        for (int i = 0; i < NP; i++) ts[i] = WIDTH'(x[i]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check_all_zero("midrun reset");
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            check($sformatf("aborted no done +%0d", cyc), real'(done), 0.0, 0.0);
        end

        load_mixed();
        run_frame("post-reset", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
